// File: rtl/mp_regfile_pkg.sv
// Shared constants, helper function and default slice types for the multi-port register file.
package mp_regfile_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_DEPTH  = 32;

   localparam logic [DEFAULT_DATA_W-1:0] ZERO_DATA = '0;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   typedef logic [DEFAULT_DATA_W-1:0]        data_t;
   typedef logic [clog2(DEFAULT_DEPTH)-1:0]  addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at write-back, with sticky duplicate-issue error.
module rf_scoreboard
   import mp_regfile_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int NUM_RD = 2,
   parameter int ADDR_W = clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issueVld,
   input  logic [ADDR_W-1:0]        issueAddr,
   input  logic [1:0]               wrEn,
   input  logic [2*ADDR_W-1:0]      wrAddr,
   input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
   output logic [DEPTH-1:0]         busyVec,
   output logic [NUM_RD-1:0]        rdBusy,
   output logic                     errDupIssue
);

   logic [DEPTH-1:0] busyNext;
   logic             issueCleared;
   logic             dupIssue;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      busyNext = busyVec;
      for (int i = 0; i < 2; i++) begin
         if (wrEn[i]) busyNext[wrAddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
      // The set is applied last so an issue beats a same-cycle clear of the same register.
      if (issueVld) busyNext[issueAddr] = 1'b1;
   end

   always_comb begin
      issueCleared = (wrEn[0] && wrAddr[0 +: ADDR_W] == issueAddr) ||
                     (wrEn[1] && wrAddr[ADDR_W +: ADDR_W] == issueAddr);
      dupIssue     = issueVld && busyVec[issueAddr] && !issueCleared;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyVec     <= '0;
         rdBusy      <= '0;
         errDupIssue <= 1'b0;
      end else begin
         busyVec     <= busyNext;
         errDupIssue <= errDupIssue | dupIssue;
         for (int k = 0; k < NUM_RD; k++) begin
            rdBusy[k] <= busyNext[rdAddr[k*ADDR_W +: ADDR_W]];
         end
      end
   end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file: NUM_RD registered read ports with write bypass, two write ports, scoreboard.
// Define MP_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module mp_regfile
   import mp_regfile_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int NUM_RD = 2,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [1:0]               wr_en,
   input  logic [2*ADDR_W-1:0]      wr_addr,
   input  logic [2*DATA_W-1:0]      wr_data,
   input  logic                     issue_vld,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic [DEPTH-1:0]         busy_vec,
   output logic                     err_dup_issue
);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] readNext [NUM_RD];
   logic [1:0]        wrEn;
   logic              issueVld;

`ifdef MP_REGFILE_ZERO_REG_EN
   // Writes and issues to register 0 vanish here, so storage, bypass and scoreboard never see them.
   assign wrEn[0]  = wr_en[0] && (wr_addr[0 +: ADDR_W] != '0);
   assign wrEn[1]  = wr_en[1] && (wr_addr[ADDR_W +: ADDR_W] != '0);
   assign issueVld = issue_vld && (issue_addr != '0);
`else
   assign wrEn     = wr_en;
   assign issueVld = issue_vld;
`endif

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         readNext[k] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
         if (wrEn[0] && wr_addr[0 +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])
            readNext[k] = wr_data[0 +: DATA_W];
         if (wrEn[1] && wr_addr[ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])
            readNext[k] = wr_data[DATA_W +: DATA_W];
      end
   end

   // NOTE: the storage array is reset because registers must read 0 after reset; this maps it to flops, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(ZERO_DATA);
      end else begin
         // Port 1 is written last so it wins a same-address collision.
         if (wrEn[0]) regs[wr_addr[0 +: ADDR_W]]      <= wr_data[0 +: DATA_W];
         if (wrEn[1]) regs[wr_addr[ADDR_W +: ADDR_W]] <= wr_data[DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         for (int k = 0; k < NUM_RD; k++) rd_data[k*DATA_W +: DATA_W] <= readNext[k];
      end
   end

   rf_scoreboard #(
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .issueVld    (issueVld),
      .issueAddr   (issue_addr),
      .wrEn        (wrEn),
      .wrAddr      (wr_addr),
      .rdAddr      (rd_addr),
      .busyVec     (busy_vec),
      .rdBusy      (rd_busy),
      .errDupIssue (err_dup_issue)
   );

endmodule

// File: tb/tb_mp_regfile.sv
// Directed self-checking bench for mp_regfile (default parameters: 32 x 32-bit, 2 read ports).
module tb_mp_regfile;
   import mp_regfile_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 2;
   localparam int ADDR_W = 5;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [1:0]               wr_en;
   logic [2*ADDR_W-1:0]      wr_addr;
   logic [2*DATA_W-1:0]      wr_data;
   logic                     issue_vld;
   logic [ADDR_W-1:0]        issue_addr;
   logic [DEPTH-1:0]         busy_vec;
   logic                     err_dup_issue;

   int tests  = 0;
   int failed = 0;

   mp_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_busy       (rd_busy),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .issue_vld     (issue_vld),
      .issue_addr    (issue_addr),
      .busy_vec      (busy_vec),
      .err_dup_issue (err_dup_issue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 ns after a rising edge; outputs are sampled at that same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en     = 2'b00;
      wr_addr   = '0;
      wr_data   = '0;
      issue_vld = 1'b0;
      issue_addr = '0;
   endtask

   initial begin
      data_t       d0, d1;
      logic [4:0]  a0, a1;

      rst_n   = 1'b0;
      rd_addr = '0;
      idle();
      #3;
      check("reset_rd_data", 64'(rd_data), 64'h0);
      check("reset_flags", {31'd0, err_dup_issue, busy_vec, rd_busy}, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Every address on both ports reads zero and not busy.
      for (int a = 0; a < DEPTH; a++) begin
         a0 = 5'(a);
         a1 = 5'(DEPTH - 1 - a);
         rd_addr = {a1, a0};
         step();
         check($sformatf("read_zero_%0d", a), {rd_data ^ 64'h0, 62'd0} | 64'(rd_busy), 64'h0);
      end
      check("busy_vec_after_reset", 64'(busy_vec), 64'h0);

      // Port-0 write with same-cycle read of the same address: bypass.
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd5};
      wr_data = {32'h0, 32'hDEADBEEF};
      rd_addr = {5'd0, 5'd5};
      step();
      check("bypass_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
      check("write_non_busy", 64'(busy_vec), 64'h0);
      idle();
      rd_addr = {5'd5, 5'd5};
      step();
      check("stored_5", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);

      // Both ports write address 9: port 1 wins in bypass and in storage.
      wr_en   = 2'b11;
      wr_addr = {5'd9, 5'd9};
      wr_data = {32'h22222222, 32'h11111111};
      rd_addr = {5'd9, 5'd9};
      step();
      check("collide_bypass", 64'(rd_data), 64'h22222222_22222222);
      idle();
      step();
      check("collide_stored", 64'(rd_data), 64'h22222222_22222222);

      // Scoreboard on register 7: issue sets, write clears, issue+write keeps busy.
      issue_vld  = 1'b1;
      issue_addr = 5'd7;
      rd_addr    = {5'd7, 5'd7};
      step();
      check("issue7_busy_vec", 64'(busy_vec), 64'h80);
      check("issue7_rd_busy", 64'(rd_busy), 64'h3);
      idle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'h0, 32'h00000077};
      step();
      check("wb7_busy_vec", 64'(busy_vec), 64'h0);
      check("wb7_rd_busy", 64'(rd_busy), 64'h0);
      check("wb7_data", 64'(rd_data), 64'h00000077_00000077);
      issue_vld  = 1'b1;
      issue_addr = 5'd7;
      wr_en      = 2'b10;
      wr_addr    = {5'd7, 5'd0};
      wr_data    = {32'h00000088, 32'h0};
      step();
      check("issue_wb7_busy_vec", 64'(busy_vec), 64'h80);
      check("issue_wb7_rd_busy", 64'(rd_busy), 64'h3);
      check("issue_wb7_err", 64'(err_dup_issue), 64'h0);
      // Issue onto busy 7 while a write clears it in the same cycle: legal, no error.
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      step();
      check("reissue_cleared_err", 64'(err_dup_issue), 64'h0);
      check("reissue_cleared_busy", 64'(busy_vec), 64'h80);
      idle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      step();
      check("clear7", 64'(busy_vec), 64'h0);

      // Duplicate issue of register 3 raises the sticky error.
      idle();
      issue_vld  = 1'b1;
      issue_addr = 5'd3;
      rd_addr    = {5'd3, 5'd0};
      step();
      check("issue3_busy", 64'(busy_vec), 64'h8);
      check("issue3_rd_busy", 64'(rd_busy), 64'h2);
      check("issue3_err", 64'(err_dup_issue), 64'h0);
      step();
      check("dup3_err", 64'(err_dup_issue), 64'h1);
      check("dup3_busy", 64'(busy_vec), 64'h8);
      idle();
      wr_en   = 2'b10;
      wr_addr = {5'd3, 5'd0};
      step();
      idle();
      step();
      step();
      check("err_sticky", 64'(err_dup_issue), 64'h1);
      check("clear3", 64'(busy_vec), 64'h0);

      // Register 0: hardwired zero only when the option is built in.
      wr_en      = 2'b01;
      wr_addr    = {5'd0, 5'd0};
      wr_data    = {32'h0, 32'hFFFFFFFF};
      issue_vld  = 1'b1;
      issue_addr = 5'd0;
      rd_addr    = {5'd0, 5'd0};
      step();
`ifdef MP_REGFILE_ZERO_REG_EN
      check("r0_bypass", 64'(rd_data), 64'h0);
      check("r0_busy_vec", 64'(busy_vec), 64'h0);
      check("r0_rd_busy", 64'(rd_busy), 64'h0);
`else
      check("r0_bypass", 64'(rd_data), 64'hFFFFFFFF_FFFFFFFF);
      check("r0_busy_vec", 64'(busy_vec), 64'h1);
      check("r0_rd_busy", 64'(rd_busy), 64'h3);
`endif
      idle();
      step();
`ifdef MP_REGFILE_ZERO_REG_EN
      check("r0_stored", 64'(rd_data), 64'h0);
`else
      check("r0_stored", 64'(rd_data), 64'hFFFFFFFF_FFFFFFFF);
`endif

      // Reset asserted mid-burst, between clock edges.
      d0 = 32'hA5A5A5A5;
      d1 = 32'h5A5A5A5A;
      wr_en      = 2'b11;
      wr_addr    = {5'd13, 5'd12};
      wr_data    = {d1, d0};
      issue_vld  = 1'b1;
      issue_addr = 5'd20;
      rd_addr    = {5'd13, 5'd12};
      step();
      check("burst_data", 64'(rd_data), {d1, d0});
      check("burst_busy20", 64'(busy_vec[20]), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_data", 64'(rd_data), 64'h0);
      check("async_rst_flags", {31'd0, err_dup_issue, busy_vec, rd_busy}, 64'h0);
      step();
      idle();
      rst_n = 1'b1;
      step();
      check("post_rst_regs", 64'(rd_data), 64'h0);
      check("post_rst_flags", {31'd0, err_dup_issue, busy_vec, rd_busy}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
